// File: rtl/sc_sng_bank_if.sv
// Handshake and lane bus between the stochastic number generator bank and its host/consumer.
// The master side drives batch control and lane values; the slave side returns the bitstreams.
interface sc_sng_bank_if #(
  parameter int unsigned N = 8,
  parameter int unsigned B = 8
);
  logic             start;
  logic             stall;
  logic             abort;
  logic [N*B-1:0]   data_in;
  logic [N*B-1:0]   wght_in;
  logic [N-1:0]     din;
  logic [N-1:0]     weight;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, stall, abort, data_in, wght_in,
    input  din, weight, valid, busy, done
  );

  modport slave (
    input  start, stall, abort, data_in, wght_in,
    output din, weight, valid, busy, done
  );
endinterface

// File: rtl/sc_sng_bank.sv
// N-lane unipolar stochastic number generator bank: each batch emits exactly 2^B-1 beats per lane,
// with the per-lane ones count equal to the captured lane value.
module sc_sng_bank #(
  parameter int unsigned     K      = 3,
  parameter int unsigned     B      = 8,
  parameter logic [B-1:0]    SEED_D = B'(8'h01),
  parameter logic [B-1:0]    SEED_W = B'(8'hA5)
) (
  input  logic               clk,
  input  logic               reset,
  sc_sng_bank_if.slave       bus
);

  localparam int unsigned N = 2 ** K;
  localparam logic [B-1:0] LAST_CNT = B'((1 << B) - 2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Feedback tap masks (bit t-1 set for tap t) of maximal-length Fibonacci LFSRs.
  function automatic logic [11:0] tap_mask(input int unsigned width);
    case (width)
      4:       tap_mask = 12'h00C;
      5:       tap_mask = 12'h014;
      6:       tap_mask = 12'h030;
      7:       tap_mask = 12'h060;
      8:       tap_mask = 12'h0B8;
      9:       tap_mask = 12'h110;
      10:      tap_mask = 12'h240;
      11:      tap_mask = 12'h500;
      12:      tap_mask = 12'h829;
      default: tap_mask = 12'h000;
    endcase
  endfunction

  localparam logic [B-1:0] TAPS = B'(tap_mask(B));

  if (B < 4 || B > 12) begin : g_bad_width
    $error("sc_sng_bank: B must be within 4..12");
  end
  if (SEED_D == '0 || SEED_W == '0) begin : g_zero_seed
    $error("sc_sng_bank: LFSR seeds must be nonzero");
  end
  if (SEED_D == SEED_W) begin : g_same_seed
    $error("sc_sng_bank: data and weight seeds must differ");
  end

  function automatic logic [B-1:0] lfsr_step(input logic [B-1:0] r);
    lfsr_step = {r[B-2:0], ^(r & TAPS)};
  endfunction

  // Rotation is a bijection on nonzero words, so every lane still sweeps all of 1..2^B-1.
  function automatic logic [B-1:0] rotl(input logic [B-1:0] x, input int unsigned s);
    logic [2*B-1:0] dbl;
    dbl  = {x, x};
    rotl = dbl[(2*B-1-s) -: B];
  endfunction

  logic [0:0]     state_q, state_n;
  logic [N*B-1:0] data_q, data_n;
  logic [N*B-1:0] wght_q, wght_n;
  logic [B-1:0]   lfsr_d_q, lfsr_d_n;
  logic [B-1:0]   lfsr_w_q, lfsr_w_n;
  logic [B-1:0]   cnt_q, cnt_n;
  logic [N-1:0]   din_q, din_n;
  logic [N-1:0]   weight_q, weight_n;
  logic           valid_q, valid_n;
  logic           busy_q, busy_n;
  logic           done_q, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      wght_q   <= '0;
      lfsr_d_q <= SEED_D;
      lfsr_w_q <= SEED_W;
      cnt_q    <= '0;
      din_q    <= '0;
      weight_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      data_q   <= data_n;
      wght_q   <= wght_n;
      lfsr_d_q <= lfsr_d_n;
      lfsr_w_q <= lfsr_w_n;
      cnt_q    <= cnt_n;
      din_q    <= din_n;
      weight_q <= weight_n;
      valid_q  <= valid_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next state and next registered outputs; abort outranks stall, which outranks a beat.
  always_comb begin
    state_n  = state_q;
    data_n   = data_q;
    wght_n   = wght_q;
    lfsr_d_n = lfsr_d_q;
    lfsr_w_n = lfsr_w_q;
    cnt_n    = cnt_q;
    din_n    = '0;
    weight_n = '0;
    valid_n  = 1'b0;
    done_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n  = S_RUN;
          data_n   = bus.data_in;
          wght_n   = bus.wght_in;
          lfsr_d_n = SEED_D;
          lfsr_w_n = SEED_W;
          cnt_n    = '0;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else if (!bus.stall) begin
          for (int unsigned i = 0; i < N; i++) begin
            din_n[i]    = (data_q[i*B +: B] >= rotl(lfsr_d_q, i % B));
            weight_n[i] = (wght_q[i*B +: B] >= rotl(lfsr_w_q, i % B));
          end
          valid_n  = 1'b1;
          lfsr_d_n = lfsr_step(lfsr_d_q);
          lfsr_w_n = lfsr_step(lfsr_w_q);
          cnt_n    = cnt_q + B'(1);
          if (cnt_q == LAST_CNT) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_RUN);
  end

  assign bus.din    = din_q;
  assign bus.weight = weight_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
